// File: rtl/pipe_mem_arbiter_pkg.sv
// pipe_mem_arbiter_pkg: shared state and owner encodings for the IF/MEM memory arbiter
package pipe_mem_arbiter_pkg;
   typedef enum logic {OWN_IF, OWN_DM} owner_e;
   typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;
endpackage

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: single-outstanding arbiter giving IF and MEM-stage access to one unified memory
//   clk_i/rst_i            clock, synchronous active-high reset
//   if_req_i/if_addr_i     fetch request; if_gnt_o/if_rvalid_o/if_rdata_o fetch handshake and data
//   dm_*_i                 load/store request; dm_gnt_o/dm_rvalid_o/dm_rdata_o data handshake
//   mem_*_o/mem_*_i        issue pulse and payload to memory, response from memory
//   busy_o                 a transaction is outstanding
module pipe_mem_arbiter
   import pipe_mem_arbiter_pkg::*;
#(
   parameter int X_LEN      = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 if_req_i,
   input  logic [ADDR_W-1:0]    if_addr_i,
   output logic                 if_gnt_o,
   output logic                 if_rvalid_o,
   output logic [X_LEN-1:0]     if_rdata_o,
   input  logic                 dm_req_i,
   input  logic                 dm_we_i,
   input  logic [ADDR_W-1:0]    dm_addr_i,
   input  logic [X_LEN-1:0]     dm_wdata_i,
   input  logic [X_LEN/8-1:0]   dm_be_i,
   output logic                 dm_gnt_o,
   output logic                 dm_rvalid_o,
   output logic [X_LEN-1:0]     dm_rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [X_LEN-1:0]     mem_wdata_o,
   output logic [X_LEN/8-1:0]   mem_be_o,
   input  logic                 mem_rvalid_i,
   input  logic [X_LEN-1:0]     mem_rdata_i,
   output logic                 busy_o
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   arb_state_e     state_q, state_d;
   owner_e         owner_q, owner_d;
   logic [CW-1:0]  starve_q, starve_d;
   logic           idle, rsp, force_if;
   // outputs are held quiet while reset is asserted, even with requests pending
   assign idle     = (state_q == ARB_IDLE) && !rst_i;
   assign rsp      = (state_q == ARB_WAIT) && !rst_i && mem_rvalid_i;
   assign force_if = (starve_q == CW'(STARVE_MAX));
   always_comb begin
      dm_gnt_o    = idle && dm_req_i && !(if_req_i && force_if);
      if_gnt_o    = idle && if_req_i && !dm_gnt_o;
      mem_req_o   = dm_gnt_o || if_gnt_o;
      mem_we_o    = dm_gnt_o && dm_we_i;
      mem_addr_o  = dm_gnt_o ? dm_addr_i : if_addr_i;
      mem_wdata_o = dm_gnt_o ? dm_wdata_i : '0;
      mem_be_o    = mem_we_o ? dm_be_i : '1;
      if_rvalid_o = rsp && (owner_q == OWN_IF);
      dm_rvalid_o = rsp && (owner_q == OWN_DM);
      if_rdata_o  = mem_rdata_i;
      dm_rdata_o  = mem_rdata_i;
      busy_o      = (state_q == ARB_WAIT);
      state_d     = mem_req_o ? ARB_WAIT : rsp ? ARB_IDLE : state_q;
      owner_d     = dm_gnt_o ? OWN_DM : if_gnt_o ? OWN_IF : owner_q;
      // count DM wins that left a waiting fetch behind; any other grant resets the streak
      starve_d    = (dm_gnt_o && if_req_i) ? (force_if ? starve_q : starve_q + CW'(1))
                  : mem_req_o ? '0 : starve_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_IF;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed self-checking bench for pipe_mem_arbiter
module tb_pipe_mem_arbiter;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i, dm_req_i, dm_we_i, mem_rvalid_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
   logic [3:0]  dm_be_i;
   logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o, busy_o;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   int          n_run = 0;
   int          n_fail = 0;

   pipe_mem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // one transaction with 1-cycle memory latency; requests stay as set for the next call
   task automatic txn(input string tag, input logic ir, input logic dr, input logic exp_dm,
                      input logic [31:0] rd);
      if_req_i = ir;
      dm_req_i = dr;
      #1;
      check({tag, "_dm_gnt"}, 64'(dm_gnt_o), 64'(exp_dm));
      check({tag, "_if_gnt"}, 64'(if_gnt_o), 64'(!exp_dm));
      tick();
      check({tag, "_busy"}, 64'(busy_o), 64'd1);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd;
      #1;
      check({tag, "_rv_gnt"}, {62'd0, dm_gnt_o, if_gnt_o}, 64'd0);
      check({tag, "_rvalid"}, {62'd0, dm_rvalid_o, if_rvalid_o}, exp_dm ? 64'd2 : 64'd1);
      check({tag, "_rdata"}, 64'(exp_dm ? dm_rdata_o : if_rdata_o), 64'(rd));
      tick();
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      {if_req_i, dm_req_i, dm_we_i, mem_rvalid_i} = '0;
      {if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i} = '0;
      dm_be_i = '0;
      tick();
      tick();
      check("rst_outs", {58'd0, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o, busy_o}, 64'd0);
      rst_i = 1'b0;
      tick();

      // IF alone, memory latency 2
      if_req_i  = 1'b1;
      if_addr_i = 32'h10;
      #1;
      check("if_gnt", 64'(if_gnt_o), 64'd1);
      check("if_memreq", 64'(mem_req_o), 64'd1);
      check("if_addr", 64'(mem_addr_o), 64'h10);
      check("if_we_be", {59'd0, mem_we_o, mem_be_o}, 64'h0F);
      tick();
      if_req_i = 1'b0;
      check("if_c1_busy", 64'(busy_o), 64'd1);
      check("if_c1_quiet", {61'd0, mem_req_o, if_rvalid_o, if_gnt_o}, 64'd0);
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0050_0093;
      #1;
      check("if_c2_busy", 64'(busy_o), 64'd1);
      check("if_rvalid", {62'd0, if_rvalid_o, dm_rvalid_o}, 64'd2);
      check("if_rdata", 64'(if_rdata_o), 64'h0050_0093);
      tick();
      mem_rvalid_i = 1'b0;
      check("if_done_busy", 64'(busy_o), 64'd0);

      // simultaneous IF and DM store: DM wins, IF follows after the response
      if_req_i   = 1'b1;
      if_addr_i  = 32'h20;
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_addr_i  = 32'h100;
      dm_wdata_i = 32'hDEAD_BEEF;
      dm_be_i    = 4'hF;
      #1;
      check("st_gnts", {62'd0, dm_gnt_o, if_gnt_o}, 64'd2);
      check("st_we", 64'(mem_we_o), 64'd1);
      check("st_addr", 64'(mem_addr_o), 64'h100);
      check("st_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
      tick();
      dm_req_i = 1'b0;
      dm_we_i  = 1'b0;
      check("st_wait_gnt", 64'(if_gnt_o), 64'd0);
      mem_rvalid_i = 1'b1;
      #1;
      check("st_ack", {62'd0, dm_rvalid_o, if_rvalid_o}, 64'd2);
      check("st_ack_gnt", 64'(if_gnt_o), 64'd0);
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      check("st_if_gnt", 64'(if_gnt_o), 64'd1);
      check("st_if_addr", 64'(mem_addr_o), 64'h20);
      tick();
      if_req_i = 1'b0;
      mem_rvalid_i = 1'b1;
      tick();
      mem_rvalid_i = 1'b0;

      // reset while a load is outstanding, late response afterwards
      dm_req_i  = 1'b1;
      dm_addr_i = 32'h300;
      #1;
      check("rw_gnt", 64'(dm_gnt_o), 64'd1);
      tick();
      dm_req_i = 1'b0;
      rst_i    = 1'b1;
      tick();
      rst_i        = 1'b0;
      mem_rvalid_i = 1'b1;
      #1;
      check("rw_rvalid", {62'd0, dm_rvalid_o, if_rvalid_o}, 64'd0);
      check("rw_busy", 64'(busy_o), 64'd0);
      tick();
      mem_rvalid_i = 1'b0;
      txn("rw_next", 1'b1, 1'b0, 1'b0, 32'h1111_2222);

      // build a starvation streak of 1, then a lone DM load must clear it
      txn("pre", 1'b1, 1'b1, 1'b1, 32'h3333_4444);
      if_req_i  = 1'b0;
      dm_addr_i = 32'h200;
      dm_be_i   = 4'h3;
      #1;
      check("ld_gnt", 64'(dm_gnt_o), 64'd1);
      check("ld_addr", 64'(mem_addr_o), 64'h200);
      check("ld_we_be", {59'd0, mem_we_o, mem_be_o}, 64'h0F);
      tick();
      dm_req_i     = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFE_F00D;
      #1;
      check("ld_rvalid", {62'd0, dm_rvalid_o, if_rvalid_o}, 64'd2);
      check("ld_rdata", 64'(dm_rdata_o), 64'hCAFE_F00D);
      tick();
      mem_rvalid_i = 1'b0;

      // continuous contention: DM x4, IF, DM x4, IF
      for (int i = 0; i < 10; i++)
         txn($sformatf("cont%0d", i), 1'b1, 1'b1, (i != 4) && (i != 9), 32'h1000 + i);
      if_req_i = 1'b0;
      dm_req_i = 1'b0;

      // spurious response in IDLE
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h5A5A_5A5A;
      #1;
      check("sp_outs", {58'd0, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o, busy_o}, 64'd0);
      tick();
      mem_rvalid_i = 1'b0;
      check("sp_busy", 64'(busy_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
